// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD digit collector.
//   state_t     : collector FSM state (COLLECT accepts digits, HOLD presents a word)
//   BCD_DIGIT_W : bits per BCD digit
//   BCD_MAX     : largest legal BCD digit value
package bcd_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam int         BCD_DIGIT_W = 4;
  localparam logic [3:0] BCD_MAX     = 4'd9;

endpackage

// File: rtl/bcd_digit_check.sv
// Combinational legality test for one BCD digit.
//   digit  : candidate digit (BCD_DIGIT_W bits)
//   is_bcd : 1 when digit is in 0..BCD_MAX
module bcd_digit_check
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] digit,
  output logic                   is_bcd
);

  assign is_bcd = (digit <= BCD_MAX);

endmodule

// File: rtl/bcd_digit_collector.sv
// Assembles NUM_DIGITS BCD digits (MSD first) into one word and hands it
// downstream with a valid/ready handshake. Non-BCD digits abort the partial
// word, pulse digit_err and bump a saturating error counter.
//   clk, rst     : clock, synchronous active-high reset
//   flush        : synchronous abort of the partial or held word
//   digit_in/digit_valid/digit_ready : digit input handshake
//   word_out/word_valid/word_ready   : assembled word output handshake
//   digit_err    : one-cycle pulse after a non-BCD digit is accepted
//   err_count    : saturating count of rejected digits
module bcd_digit_collector
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int ERR_CNT_W  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [BCD_DIGIT_W-1:0]          digit_in,
  input  logic                            digit_valid,
  output logic                            digit_ready,
  output logic [BCD_DIGIT_W*NUM_DIGITS-1:0] word_out,
  output logic                            word_valid,
  input  logic                            word_ready,
  output logic                            digit_err,
  output logic [ERR_CNT_W-1:0]            err_count
);

  localparam int WORD_W = BCD_DIGIT_W * NUM_DIGITS;
  localparam int CNT_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]     LAST_IDX = CNT_W'(NUM_DIGITS - 1);
  localparam logic [ERR_CNT_W-1:0] ERR_MAX  = '1;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [WORD_W-1:0]      sreg_q, sreg_d;
  logic                   err_q, err_d;
  logic [ERR_CNT_W-1:0]   errc_q, errc_d;
  logic                   is_bcd;
  logic                   digit_xfer;
  logic                   word_xfer;

  bcd_digit_check u_check (
    .digit  (digit_in),
    .is_bcd (is_bcd)
  );

  // Ready is gated by rst so nothing looks accepted while reset is held.
  assign digit_ready = (state_q == COLLECT) && !rst;
  assign word_valid  = (state_q == HOLD);
  assign word_out    = word_valid ? sreg_q : '0;
  assign digit_err   = err_q;
  assign err_count   = errc_q;

  assign digit_xfer  = digit_valid && digit_ready;
  assign word_xfer   = word_valid && word_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sreg_d  = sreg_q;
    errc_d  = errc_q;
    err_d   = 1'b0;
    if (flush) begin
      // Flush wins over any transfer this cycle; the digit is dropped silently.
      state_d = COLLECT;
      cnt_d   = '0;
      sreg_d  = '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (digit_xfer) begin
            if (is_bcd) begin
              sreg_d = (sreg_q << BCD_DIGIT_W) | WORD_W'(digit_in);
              if (cnt_q == LAST_IDX) begin
                cnt_d   = '0;
                state_d = HOLD;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end else begin
              cnt_d  = '0;
              sreg_d = '0;
              err_d  = 1'b1;
              if (errc_q != ERR_MAX) errc_d = errc_q + 1'b1;
            end
          end
        end
        HOLD: begin
          // Digits are ignored here; ready is low so none can transfer.
          if (word_xfer) begin
            state_d = COLLECT;
            sreg_d  = '0;
          end
        end
        default: begin
          state_d = COLLECT;
          cnt_d   = '0;
          sreg_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      cnt_q   <= '0;
      sreg_q  <= '0;
      err_q   <= 1'b0;
      errc_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sreg_q  <= sreg_d;
      err_q   <= err_d;
      errc_q  <= errc_d;
    end
  end

endmodule

// File: tb/tb_bcd_digit_collector.sv
// Self-checking bench for bcd_digit_collector: directed scenarios with literal
// expectations, then randomized traffic, all compared every cycle against a
// digit-queue reference model.
module tb_bcd_digit_collector;

  localparam int N     = 4;
  localparam int EW    = 8;
  localparam int EMAX  = (1 << EW) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              flush = 1'b0;
  logic [3:0]        digit_in = '0;
  logic              digit_valid = 1'b0;
  logic              digit_ready;
  logic [4*N-1:0]    word_out;
  logic              word_valid;
  logic              word_ready = 1'b0;
  logic              digit_err;
  logic [EW-1:0]     err_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  bcd_digit_collector #(.NUM_DIGITS(N), .ERR_CNT_W(EW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .digit_in    (digit_in),
    .digit_valid (digit_valid),
    .digit_ready (digit_ready),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .digit_err   (digit_err),
    .err_count   (err_count)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending digits, a held word and an error tally.
  int        m_q[$];
  bit        m_hold  = 1'b0;
  int        m_word  = 0;
  bit        m_pulse = 1'b0;
  int        m_errc  = 0;

  always @(posedge clk) begin
    if (rst) begin
      m_q.delete(); m_hold = 0; m_word = 0; m_pulse = 0; m_errc = 0;
    end else if (flush) begin
      m_q.delete(); m_hold = 0; m_word = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (m_hold) begin
        if (word_ready) begin m_hold = 0; m_word = 0; end
      end else if (digit_valid) begin
        if (int'(digit_in) > 9) begin
          m_q.delete();
          m_pulse = 1;
          if (m_errc < EMAX) m_errc++;
        end else begin
          m_q.push_back(int'(digit_in));
          if (m_q.size() == N) begin
            m_word = 0;
            foreach (m_q[i]) m_word = m_word * 16 + m_q[i];
            m_hold = 1;
            m_q.delete();
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("word_valid",  int'(word_valid),  int'(m_hold));
      chk("word_out",    int'(word_out),    m_hold ? m_word : 0);
      chk("digit_ready", int'(digit_ready), int'(!m_hold && !rst));
      chk("digit_err",   int'(digit_err),   int'(m_pulse));
      chk("err_count",   int'(err_count),   m_errc);
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic put(input int d);
    digit_in = 4'(d); digit_valid = 1'b1;
    cyc();
    digit_valid = 1'b0;
  endtask

  int pulses;

  initial begin
    rst = 1'b1;
    cyc(); cyc();
    chk_en = 1'b1;
    chk("rst_ready_low", int'(digit_ready), 0);
    chk("rst_word_valid", int'(word_valid), 0);
    chk("rst_err_count", int'(err_count), 0);
    rst = 1'b0;
    #1 chk("ready_after_rst", int'(digit_ready), 1);
    cyc();

    // 1,2,3,6 held with word_ready low; digits during HOLD are ignored
    word_ready = 1'b0;
    put(1); put(2); put(3); put(6);
    chk("w1236_valid", int'(word_valid), 1);
    chk("w1236_out", int'(word_out), 'h1236);
    chk("w1236_ready", int'(digit_ready), 0);
    put(5); put(7);
    chk("w1236_stable", int'(word_out), 'h1236);
    word_ready = 1'b1; cyc(); word_ready = 1'b0;
    chk("w1236_released", int'(word_valid), 0);
    chk("w1236_ready_back", int'(digit_ready), 1);

    // 9,9,9,9 with word_ready high: valid for a single cycle
    word_ready = 1'b1;
    put(9); put(9); put(9); put(9);
    chk("w9999_out", int'(word_out), 'h9999);
    cyc();
    chk("w9999_gone", int'(word_valid), 0);
    chk("w9999_ready", int'(digit_ready), 1);
    word_ready = 1'b0;

    // 4,5,12 aborts; then 0,0,0,3
    put(4); put(5); put(12);
    chk("err_pulse", int'(digit_err), 1);
    chk("err_cnt1", int'(err_count), 1);
    cyc();
    chk("err_pulse_end", int'(digit_err), 0);
    put(0); put(0); put(0); put(3);
    chk("w0003_out", int'(word_out), 'h0003);
    word_ready = 1'b1; cyc(); word_ready = 1'b0;

    // 7,8 then flush with digit 2: silently dropped
    put(7); put(8);
    flush = 1'b1; digit_in = 4'd2; digit_valid = 1'b1;
    cyc();
    flush = 1'b0; digit_valid = 1'b0;
    chk("flush_no_err", int'(digit_err), 0);
    chk("flush_errcnt", int'(err_count), 1);
    put(0); put(0); put(1); put(5);
    chk("w0015_out", int'(word_out), 'h0015);

    // flush in HOLD drops the word
    flush = 1'b1; cyc(); flush = 1'b0;
    chk("flush_hold", int'(word_valid), 0);

    // reset while holding 2468
    put(2); put(4); put(6); put(8);
    chk("w2468_out", int'(word_out), 'h2468);
    rst = 1'b1; cyc();
    chk("rst_hold_valid", int'(word_valid), 0);
    chk("rst_hold_out", int'(word_out), 0);
    chk("rst_hold_errc", int'(err_count), 0);
    chk("rst_hold_ready", int'(digit_ready), 0);
    rst = 1'b0;
    #1 chk("rst_release_ready", int'(digit_ready), 1);
    cyc();

    // 300 invalid digits: saturate at 255, one pulse per digit
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      put(15);
      if (digit_err) pulses++;
    end
    chk("sat_pulses", pulses, 300);
    chk("sat_errcnt", int'(err_count), 255);
    cyc();
    chk("sat_pulse_end", int'(digit_err), 0);
    put(3); put(15);
    chk("sat_hold", int'(err_count), 255);

    // randomized traffic
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      flush       = ($urandom_range(0, 29) == 0);
      digit_valid = ($urandom_range(0, 9) < 7);
      digit_in    = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                : 4'($urandom_range(0, 9));
      word_ready  = ($urandom_range(0, 1) == 1);
      cyc();
    end
    rst = 1'b0; flush = 1'b0; digit_valid = 1'b0; word_ready = 1'b0;
    cyc();
    chk_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
